// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display multiplexer.
package display_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned SEG_W            = 7;
    localparam int unsigned AN_W             = 2;
    localparam int unsigned DEF_ON_CYCLES    = 24000;
    localparam int unsigned DEF_BLANK_CYCLES = 480;
    localparam int unsigned DEF_CNT_W        = 15;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
    localparam logic [AN_W-1:0]  AN_OFF  = 2'b11;
    localparam logic [AN_W-1:0]  AN_DIG0 = 2'b10;
    localparam logic [AN_W-1:0]  AN_DIG1 = 2'b01;

    typedef enum logic [1:0] {S_BLANK0, S_ON0, S_BLANK1, S_ON1} state_t;

    // Fixed rotation: blank before each digit so the previous pattern never ghosts.
    function automatic state_t next_state(input state_t s);
        state_t n;
        n = S_BLANK0;
        case (s)
            S_BLANK0: n = S_ON0;
            S_ON0:    n = S_BLANK1;
            S_BLANK1: n = S_ON1;
            S_ON1:    n = S_BLANK0;
        endcase
        return n;
    endfunction

    function automatic logic [AN_W-1:0] anodes_for(input state_t s);
        logic [AN_W-1:0] a;
        a = AN_OFF;
        case (s)
            S_ON0:   a = AN_DIG0;
            S_ON1:   a = AN_DIG1;
            default: a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// Hex digit to active-low seven-segment pattern (bit 0 = a ... bit 6 = g).
module seven_seg_dec
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] hex_in,
    output logic [SEG_W-1:0]   seg_n_c
);

    always_comb begin
        seg_n_c = SEG_OFF;
        case (hex_in)
            4'h0: seg_n_c = 7'b1000000;
            4'h1: seg_n_c = 7'b1111001;
            4'h2: seg_n_c = 7'b0100100;
            4'h3: seg_n_c = 7'b0110000;
            4'h4: seg_n_c = 7'b0011001;
            4'h5: seg_n_c = 7'b0010010;
            4'h6: seg_n_c = 7'b0000010;
            4'h7: seg_n_c = 7'b1111000;
            4'h8: seg_n_c = 7'b0000000;
            4'h9: seg_n_c = 7'b0010000;
            4'hA: seg_n_c = 7'b0001000;
            4'hB: seg_n_c = 7'b0000011;
            4'hC: seg_n_c = 7'b1000110;
            4'hD: seg_n_c = 7'b0100001;
            4'hE: seg_n_c = 7'b0000110;
            4'hF: seg_n_c = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexes two synchronized switch nibbles onto a dual common-anode display
// through a single shared decoder, with a blanking gap before each digit.
module display_mux_ctrl
    import display_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = DEF_ON_CYCLES,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DIGIT_W-1:0] switch1,
    input  logic [DIGIT_W-1:0] switch2,
    output logic [SEG_W-1:0]   seg,
    output logic [AN_W-1:0]    an_n
);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] sw1_meta_q, sw1_meta_d, sw1_sync_q, sw1_sync_d;
    logic [DIGIT_W-1:0] sw2_meta_q, sw2_meta_d, sw2_sync_q, sw2_sync_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [AN_W-1:0]    an_n_q, an_n_d;
    logic               first_q, first_d;
    logic               in_blank_c;
    logic               last_c;
    logic               latch_c;
    logic [SEG_W-1:0]   dec_seg_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_BLANK0;
            cnt_q      <= '0;
            sw1_meta_q <= '0;
            sw1_sync_q <= '0;
            sw2_meta_q <= '0;
            sw2_sync_q <= '0;
            digit_q    <= '0;
            seg_q      <= SEG_OFF;
            an_n_q     <= AN_OFF;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sw1_meta_q <= sw1_meta_d;
            sw1_sync_q <= sw1_sync_d;
            sw2_meta_q <= sw2_meta_d;
            sw2_sync_q <= sw2_sync_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_n_q     <= an_n_d;
            first_q    <= first_d;
        end
    end

    // Next state, dwell counter and anode drive for the state being entered.
    always_comb begin
        sw1_meta_d = switch1;
        sw1_sync_d = sw1_meta_q;
        sw2_meta_d = switch2;
        sw2_sync_d = sw2_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        first_d    = 1'b0;
        in_blank_c = (state_q == S_BLANK0) || (state_q == S_BLANK1);
        last_c     = in_blank_c ? (cnt_q == BLANK_LAST) : (cnt_q == ON_LAST);
        if (last_c) begin
            state_d = next_state(state_q);
            cnt_d   = '0;
        end
        an_n_d = anodes_for(state_d);
    end

    // The first edge after reset stands in for the S_BLANK0 entry edge.
    always_comb begin
        latch_c = first_q || (last_c && !in_blank_c);
        digit_d = digit_q;
        if (latch_c) begin
            digit_d = (!first_q && (state_d == S_BLANK1)) ? sw2_sync_q : sw1_sync_q;
        end
    end

    seven_seg_dec u_dec (
        .hex_in  (digit_d),
        .seg_n_c (dec_seg_c)
    );

    assign seg_d = dec_seg_c;
    assign seg   = seg_q;
    assign an_n  = an_n_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed + random bench for display_mux_ctrl against a cycle-time reference model.
module tb_display_mux_ctrl;

    localparam int unsigned ON  = 4;
    localparam int unsigned BL  = 2;
    localparam int unsigned PER = 2 * (ON + BL);
    localparam int unsigned HN  = 4096;

    logic       clk;
    logic       reset_n;
    logic [3:0] switch1;
    logic [3:0] switch2;
    logic [6:0] seg;
    logic [1:0] an_n;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    logic [3:0] h1 [HN];
    logic [3:0] h2 [HN];
    logic [6:0] exp_seg;
    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_mux_ctrl #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL),
        .CNT_W        (15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .switch1 (switch1),
        .switch2 (switch2),
        .seg     (seg),
        .an_n    (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Anodes from elapsed cycles since reset release: blank0, on0, blank1, on1.
    function automatic logic [1:0] exp_an(input int t);
        int p;
        p = t % PER;
        if (p < BL)           return 2'b11;
        if (p < BL + ON)      return 2'b10;
        if (p < 2 * BL + ON)  return 2'b11;
        return 2'b01;
    endfunction

    function automatic logic [3:0] synced(input logic [3:0] hist [HN], input int edge_idx);
        if (edge_idx < 3) return 4'h0;
        return hist[edge_idx - 3];
    endfunction

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, expv);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
        end
    endtask

    task automatic step();
        h1[e] = switch1;
        h2[e] = switch2;
        @(posedge clk);
        #1;
        e++;
        if (e == 1 || (e % PER) == 0)       exp_seg = dec_tab[synced(h1, e)];
        else if ((e % PER) == (BL + ON))    exp_seg = dec_tab[synced(h2, e)];
        chk2("an_n", an_n, exp_an(e));
        chk7("seg", seg, exp_seg);
        total++;
        assert (an_n !== 2'b00) else begin
            bad++;
            $error("FAIL an_illegal edge=%0d observed=%b expected=not 00", e, an_n);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk2("rst_an_async", an_n, 2'b11);
        chk7("rst_seg_async", seg, 7'h7F);
        repeat (2) @(negedge clk);
        chk2("rst_an_held", an_n, 2'b11);
        chk7("rst_seg_held", seg, 7'h7F);
        reset_n = 1'b1;
        e       = 0;
        exp_seg = 7'h7F;
    endtask

    initial begin
        reset_n = 1'b1;
        switch1 = 4'h0;
        switch2 = 4'h8;
        exp_seg = 7'h7F;
        #2;
        do_reset();

        // Held values 0 / 8.
        steps(3 * PER);

        // Digit 0 changes 1 -> F in the middle of its ON window.
        switch1 = 4'h1;
        switch2 = 4'h5;
        steps(2 * PER);
        while ((e % PER) != BL + 1) step();
        switch1 = 4'hF;
        steps(2 * PER);

        // Asynchronous reset in S_ON1 with the dwell counter at 2.
        while ((e % PER) != 2 * BL + ON + 2) step();
        #3;
        do_reset();
        steps(2 * PER);

        // Sweep every nibble on both digits.
        for (int v = 0; v < 16; v++) begin
            switch1 = 4'(v);
            switch2 = 4'(15 - v);
            steps(2 * PER);
        end

        // Random switch activity, including changes inside ON windows.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) switch1 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) switch2 = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_mux_ctrl.md
# display_mux_ctrl

Time-multiplexing controller for the dual common-anode seven-segment display. It shares one hex-to-seven-segment decoder between two 4-bit switch inputs by alternating the two digit anodes. A blanking interval separates the digits so there is no ghosting. It sits between the synchronized DIP-switch inputs and the display pins, alongside the LED sum logic, which uses the same switch values.

## Interface
Parameters:
- ON_CYCLES, 24000 — clock cycles each digit stays lit. At 48 MHz this is 500 µs. Must be ≥1.
- BLANK_CYCLES, 480 — clock cycles with both anodes off before each digit. Must be ≥1.
- CNT_W, 15 — counter width. Must hold max(ON_CYCLES, BLANK_CYCLES) − 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- switch1  in  4  digit-0 value (asynchronous DIP switches).
- switch2  in  4  digit-1 value (asynchronous DIP switches).
- seg  out  7  segment cathodes, active low. seg[0]=a … seg[6]=g.
- an_n  out  2  anode enables, active low. an_n[0] is digit 0, an_n[1] is digit 1.

## Operation
- Each switch bus passes through a 2-flop synchronizer. Only synchronized values are used internally.
- FSM states, in order: S_BLANK0 → S_ON0 → S_BLANK1 → S_ON1 → S_BLANK0, and so on.
- A down-counter, or an up-counter compared against N−1, times each state:
  - BLANK states last BLANK_CYCLES.
  - ON states last ON_CYCLES.
  - The counter clears on every state transition.
- On the edge that enters S_BLANKx:
  - the synchronized switch value for digit x is latched into the digit register;
  - seg is loaded with its decoded pattern.
- The latched value holds unchanged through the following S_ONx. Switch changes during ON are not shown until that digit's next BLANK entry.
- Outputs by state:
  - S_BLANK0 and S_BLANK1: an_n = 2'b11.
  - S_ON0: an_n = 2'b10.
  - S_ON1: an_n = 2'b01.
  - an_n = 2'b00 is illegal and must never occur.
- Decoding covers hex 0–F, active low. Examples:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - F → 7'b0001110
- Reset (reset_n low, any time, including mid-state):
  - an_n = 2'b11 and seg = 7'b1111111 immediately, without waiting for a clock edge;
  - FSM goes to S_BLANK0, counter to 0, synchronizers and digit registers to 0.
- After reset release, the first clock edge counts as the first S_BLANK0 cycle. The latch into the digit register happens on that edge.

## Timing
- All outputs are registered. There is no combinational path from inputs to pins.
- Refresh period is 2×(ON_CYCLES + BLANK_CYCLES) cycles. With the defaults that is 48960 cycles, about 980 Hz per digit.
- seg is stable for all BLANK_CYCLES before the matching anode is enabled.
- an_n changes on the same edge as the state transition. seg changes only on BLANK-entry edges.
- Latency from switch change to display: 2 synchronizer cycles, plus the wait for the next S_BLANKx entry of that digit, plus BLANK_CYCLES until lit. Worst case is 2 + 2×(ON+BLANK) + BLANK cycles.
- Counter terminal compare is at N−1. N=1 therefore means a one-cycle state.

## Structure
Package display_pkg holds:
- state enum state_t {S_BLANK0, S_ON0, S_BLANK1, S_ON1};
- SEG_OFF = 7'b1111111;
- default timing constants.

Sub-module seven_seg_dec:
- purely combinational;
- 4-bit in, 7-bit active-low out;
- instantiated exactly once, so the decoder is genuinely shared;
- its input is muxed by the upcoming digit select.

## Test plan
All scenarios use ON_CYCLES=4, BLANK_CYCLES=2.
- Reset: reset_n low with the clock running → an_n=2'b11 and seg=7'h7F with no clock edge needed. After release: 2 cycles of an_n=11, then 4 cycles of an_n=10, then 2 cycles of 11, then 4 cycles of 01. Period is 12 cycles.
- Values: switch1=0, switch2=8, held → seg=7'b1000000 whenever an_n=10, seg=7'b0000000 whenever an_n=01. an_n=00 is never observed (assertion).
- Mid-display change: switch1 goes 1→F during S_ON0 → seg stays 7'b1111001 until S_ON0 ends. The next S_BLANK0/S_ON0 shows 7'b0001110. Digit 1 is unaffected.
- Async reset mid-S_ON1 (counter=2) → outputs are 11/7F before the next edge. After release the sequence restarts from S_BLANK0 with full counts.
- Sweep: all 16 values on switch1 and on switch2 → seg matches the decoder table for each digit. seg is already stable on the cycle before each anode enables.
